// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the shift sequencer slice.
//   state_t   - sequencer FSM states
//   DIR_LEFT  - direction input value selecting a left (zero-fill) shift
//   DIR_RIGHT - direction input value selecting a right (sign-fill) shift
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: control/data bundle between a controller (master) and
// the shift sequencer (slave).
//   load, load_data        - operand capture request and value
//   start, direction, steps - sequence launch request and its arguments
//   q, busy, done, overflow - running value and status back to the controller
interface shift_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 3
);

  logic              load;
  logic [WIDTH-1:0]  load_data;
  logic              start;
  logic              direction;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output load, load_data, start, direction, steps,
    input  q, busy, done, overflow
  );

  modport slave (
    input  load, load_data, start, direction, steps,
    output q, busy, done, overflow
  );

endinterface

// File: rtl/shift_tick_gen.sv
// shift_tick_gen: paces the shift sequence. Counts 0..DIV-1 and asserts tick
// combinationally while the count sits at DIV-1, then wraps.
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - restart the count from 0 (applied when a sequence starts)
//   tick - one-cycle enable every DIV cycles
module shift_tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: holds a signed operand and applies a number of single-bit
// arithmetic shifts, one per paced tick, reporting busy/done and a sticky
// overflow flag.
//   clk - system clock (rising edge)
//   rst - asynchronous active-high reset
//   bus - shift_sequencer_if.slave: load/load_data/start/direction/steps in,
//         q/busy/done/overflow out
// Optional build macro SHIFT_SAT_EN: an overflowing left shift saturates q to
// the extreme of the pre-shift sign instead of wrapping.
import shift_pkg::*;

module shift_sequencer #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 3,
  parameter int DIV    = 25000000
) (
  input logic                clk,
  input logic                rst,
  shift_sequencer_if.slave   bus
);

  state_t            state, state_nx;
  logic [WIDTH-1:0]  q_r, q_nx;
  logic [STEP_W-1:0] rem, rem_nx;
  logic              dir_r, dir_nx;
  logic              ov_r, ov_nx;
  logic              tick;
  logic              clr;

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign bus.q        = q_r;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.overflow = ov_r;

  always_comb begin
    state_nx = state;
    q_nx     = q_r;
    rem_nx   = rem;
    dir_nx   = dir_r;
    ov_nx    = ov_r;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        // Load is applied first so a same-cycle start works on the new value.
        if (bus.load) begin
          q_nx  = bus.load_data;
          ov_nx = 1'b0;
        end
        if (bus.start) begin
          if (bus.steps != '0) begin
            dir_nx   = bus.direction;
            rem_nx   = bus.steps;
            clr      = 1'b1;
            ov_nx    = 1'b0;
            state_nx = RUN;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        if (tick) begin
          if (dir_r == DIR_LEFT) begin
            if (q_r[WIDTH-1] != q_r[WIDTH-2]) begin
              ov_nx = 1'b1;
`ifdef SHIFT_SAT_EN
              q_nx = q_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
`else
              q_nx = {q_r[WIDTH-2:0], 1'b0};
`endif
            end else begin
              q_nx = {q_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            q_nx = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          end
          rem_nx = rem - STEP_W'(1);
          if (rem == STEP_W'(1)) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q_r   <= '0;
      rem   <= '0;
      dir_r <= DIR_RIGHT;
      ov_r  <= 1'b0;
    end else begin
      state <= state_nx;
      q_r   <= q_nx;
      rem   <= rem_nx;
      dir_r <= dir_nx;
      ov_r  <= ov_nx;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and randomized sequences against an integer
// reference model of the shift rules (WIDTH=4, STEP_W=3, DIV=2).
module tb_shift_sequencer;

  localparam int W    = 4;
  localparam int SW   = 3;
  localparam int DIV  = 2;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: operand as a signed integer and the sticky flag.
  int   mq  = 0;
  bit   mov = 1'b0;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  shift_sequencer #(.WIDTH(W), .STEP_W(SW), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int v);
    int r;
    r = v & ((1 << W) - 1);
    if (r > MAXV) r = r - (1 << W);
    return r;
  endfunction

  function automatic logic [W-1:0] as_bits(input int v);
    logic [31:0] t;
    t = v;
    return t[W-1:0];
  endfunction

  function automatic int as_int(input logic [W-1:0] b);
    return wrap(int'(b));
  endfunction

  task automatic model_shift(input bit left);
    int r;
    if (left) begin
      r = mq * 2;
      if (r > MAXV || r < MINV) begin
        mov = 1'b1;
`ifdef SHIFT_SAT_EN
        mq = (mq >= 0) ? MAXV : MINV;
`else
        mq = wrap(r);
`endif
      end else begin
        mq = r;
      end
    end else begin
      mq = mq >>> 1;
    end
  endtask

  task automatic check_all(input string tag, input bit eb, input bit ed);
    chk({tag, ".q"}, 32'(bus.q), 32'(as_bits(mq)));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    chk({tag, ".done"}, 32'(bus.done), 32'(ed));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(mov));
  endtask

  // Runs one sequence from IDLE. Called #1 after an edge; returns #1 after the
  // edge at which the sequencer is back in IDLE. inject>0 pulses load=0000
  // plus start on the edge numbered inject (counted from the start edge).
  task automatic run_seq(input logic [W-1:0] lv, input bit do_load, input bit same,
                         input bit dir, input int st, input int inject);
    int applied = 0;
    int n;
    int last;
    if (do_load && !same) begin
      bus.load      = 1'b1;
      bus.load_data = lv;
      @(posedge clk); #1;
      bus.load = 1'b0;
      mq  = as_int(lv);
      mov = 1'b0;
      check_all("load", 1'b0, 1'b0);
    end
    bus.start     = 1'b1;
    bus.direction = dir;
    bus.steps     = SW'(st);
    if (same) begin
      bus.load      = 1'b1;
      bus.load_data = lv;
      mq  = as_int(lv);
      mov = 1'b0;
    end
    if (st != 0) mov = 1'b0;
    last = st * DIV + 1;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk); #1;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      // Arguments are only sampled at start; scramble them afterwards.
      bus.direction = 1'($urandom);
      bus.steps     = SW'($urandom);
      n = (st == 0) ? 0 : ((t / DIV < st) ? t / DIV : st);
      while (applied < n) begin
        model_shift(dir);
        applied++;
      end
      check_all("seq", (st != 0) && (t < st * DIV), t == st * DIV);
      if (inject != 0 && t + 1 == inject) begin
        bus.load      = 1'b1;
        bus.load_data = '0;
        bus.start     = 1'b1;
      end
    end
  endtask

  initial begin
    bus.load      = 1'b0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.direction = 1'b0;
    bus.steps     = '0;

    #1;
    check_all("reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_reset", 1'b0, 1'b0);

    // Right shift of a negative value.
    run_seq(4'b1011, 1'b1, 1'b0, 1'b0, 2, 0);
    // Left shift into the sign bit.
    run_seq(4'b0011, 1'b1, 1'b0, 1'b1, 2, 0);
    // Load clears the sticky flag left over from the previous sequence.
    run_seq(4'b0101, 1'b1, 1'b0, 1'b0, 0, 0);
    // -1 stays -1 for the maximum step count.
    run_seq(4'b1111, 1'b1, 1'b0, 1'b0, 7, 0);
    // Positive value converges to 0.
    run_seq(4'b0111, 1'b1, 1'b0, 1'b0, 5, 0);
    // Zero steps: single done cycle, q unchanged.
    run_seq(4'b0101, 1'b1, 1'b0, 1'b0, 0, 0);
    run_seq(4'b0000, 1'b0, 1'b0, 1'b1, 0, 0);
    // Load/start pulses during RUN are ignored.
    run_seq(4'b0110, 1'b1, 1'b0, 1'b0, 3, 3);
    run_seq(4'b1001, 1'b1, 1'b0, 1'b1, 3, 4);
    // Same-cycle load and start.
    run_seq(4'b1000, 1'b1, 1'b1, 1'b0, 1, 0);
    // Negative left overflow (saturates to min in the saturating build).
    run_seq(4'b1010, 1'b1, 1'b0, 1'b1, 3, 0);

    for (int i = 0; i < 25; i++) begin
      int st;
      int inj;
      st  = int'($urandom_range(0, 7));
      inj = (st != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, st * DIV)) : 0;
      run_seq(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), st, inj);
    end

    // Asynchronous reset in the middle of a sequence.
    bus.load      = 1'b1;
    bus.load_data = 4'b0110;
    @(posedge clk); #1;
    bus.load      = 1'b0;
    bus.start     = 1'b1;
    bus.direction = 1'b1;
    bus.steps     = 3'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid.busy_before", 32'(bus.busy), 32'd1);
    chk("mid.ovf_before", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    #1;
    mq  = 0;
    mov = 1'b0;
    check_all("async_rst", 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      check_all("after_rst", 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
